return_address_stack: RTL and testbench
=======================================

# return_address_stack

Hardware call/return stack that produces the branch target for returns in the EX stage. It pushes the return address on a CALL and pops it on a RET, driving `Stack_Out_EX` and `Stack_Out_Enable_EX` to the branch-address mux. When `Stack_Out_Enable_EX` is high, that mux selects the popped address over the instruction immediate. The block sits beside the EX-stage branch logic and is the producer end of that stack-output interface.

## Interface
Parameters:
- `DEPTH`, 8: number of stack entries; power of two, ≥ 2.
- `ADDR_W`, 16: width of one return address.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Call_EX`  in  1  CALL in EX; push `Return_Addr_EX`.
- `Ret_EX`  in  1  RET in EX; pop the top entry.
- `Return_Addr_EX`  in  `ADDR_W`  address to push, normally PC+1.
- `Stall_EX`  in  1  suppresses every state update this cycle.
- `Flush`  in  1  synchronous clear of the stack and the sticky flags.
- `Stack_Out_EX`  out  `ADDR_W`  top-of-stack return address.
- `Stack_Out_Enable_EX`  out  1  a valid return target is being supplied.
- `Stack_Full`  out  1  count == `DEPTH`.
- `Stack_Empty`  out  1  count == 0.
- `Stack_Overflow`  out  1  sticky: a push was lost or overwrote an entry.
- `Stack_Underflow`  out  1  sticky: RET seen while empty.

## Operation
State:
- `top` pointer, log2(`DEPTH`) bits.
- `count`, 0..`DEPTH`.
- entry array, not reset.

Outputs (combinational from current state and inputs):
- `Stack_Out_Enable_EX` = `Ret_EX` & !`Stack_Empty`.
- `Stack_Out_EX` = entry[`top`] when enabled, else all zeros.
- The output is independent of `Stall_EX`.

Updates (only when `Stall_EX`=0 and `Flush`=0):
- Push only: `top` ← `top`+1 mod `DEPTH`; entry[new `top`] ← `Return_Addr_EX`; `count`+1.
- Pop only, non-empty: `top` ← `top`−1 mod `DEPTH`; `count`−1.
- Pop only, empty: no change; `Stack_Underflow` ← 1. The mux then falls back to the immediate.
- Call and Ret together, non-empty: entry[`top`] ← `Return_Addr_EX`; `top` and `count` unchanged. This is the tail-call replace; the old top is still output this cycle.
- Call and Ret together, empty: behaves as a push; `Stack_Underflow` ← 1.
- Push when full: behaviour is set by the macro (see Configuration).

Priority and reset:
- `Flush` overrides all other inputs, including `Stall_EX`: `top`←0, `count`←0, both sticky flags ← 0.
- Reset values: `top`=0, `count`=0, `Stack_Full`=0, `Stack_Empty`=1, `Stack_Overflow`=0, `Stack_Underflow`=0, `Stack_Out_Enable_EX`=0, `Stack_Out_EX`=0.

## Timing
- Pop data is available in the same cycle as `Ret_EX`, with zero latency, through a combinational read path.
- A push is visible at the top of stack on the cycle after the `Call_EX` edge. A RET in the cycle following a CALL returns the new address.
- `Stack_Full`, `Stack_Empty` and the flags are registered-state decodes. They change on the edge after the causing event.
- Asserting `rst_n` low mid-sequence clears state immediately. Outputs reach their reset values without waiting for a clock.

## Configuration
- Macro: `RAS_CIRCULAR_EN`.
- Defined: a push when full overwrites the oldest entry. `top` advances, `count` stays at `DEPTH`, and `Stack_Overflow` ← 1.
- Undefined: a push when full is dropped. No change to `top`, `count` or entries, and `Stack_Overflow` ← 1.
- The tail-call replace when full is not an overflow in either mode.

## Structure
- Package `ras_pkg`:
  - default `ADDR_W` and `DEPTH`;
  - `RAS_PTR_W` = $clog2(`DEPTH`);
  - a typedef for the return-address word.
- Sub-module `ras_storage`: a `DEPTH`×`ADDR_W` register array with one write port (`we`, `waddr`, `wdata`) and one combinational read port (`raddr`, `rdata`). Pointer, count and flag logic stay in `return_address_stack`.

## Test plan
- Reset, then Ret_EX=1 → `Stack_Out_Enable_EX`=0, `Stack_Out_EX`=0; next cycle `Stack_Underflow`=1, `Stack_Empty`=1.
- Push 0x0010, 0x0020, 0x0030; then Ret on 3 consecutive cycles → outputs 0x0030, 0x0020, 0x0010 with enable=1, then `Stack_Empty`=1.
- Push 0x0100, then Call+Ret with addr 0x0200 → output 0x0100 this cycle; next Ret → 0x0200; count=0 afterwards.
- With `DEPTH`=8, push 0x0001..0x0009:
  - `RAS_CIRCULAR_EN` defined: 8 pops yield 0x0009..0x0002.
  - `RAS_CIRCULAR_EN` undefined: 8 pops yield 0x0008..0x0001.
  - Both modes: `Stack_Overflow`=1.
- Stall_EX=1 with Call 0x0555 → no count change. Flush with 3 entries → next cycle `Stack_Empty`=1 and flags cleared. `rst_n` low mid-push → outputs at reset values asynchronously.

Source files
------------

// File: rtl/ras_pkg.sv
// ras_pkg: shared defaults and types for the return address stack.
//   RAS_DEPTH  - default number of stack entries (power of two, >= 2)
//   RAS_ADDR_W - default width of one return address
//   RAS_PTR_W  - width of the top-of-stack pointer for the default depth
//   ras_addr_t - return-address word at the default width
package ras_pkg;

  localparam int unsigned RAS_DEPTH  = 8;
  localparam int unsigned RAS_ADDR_W = 16;
  localparam int unsigned RAS_PTR_W  = $clog2(RAS_DEPTH);

  typedef logic [RAS_ADDR_W-1:0] ras_addr_t;

endpackage

// File: rtl/ras_storage.sv
// ras_storage: DEPTH x ADDR_W register array for the return address stack.
// Entries are intentionally not reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index (combinational read)
//   rdata - entry at raddr
module ras_storage
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH  = RAS_DEPTH,
  parameter int unsigned ADDR_W = RAS_ADDR_W,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_address_stack.sv
// return_address_stack: call/return stack supplying the EX-stage branch
// target for RET instructions.
//   clk, rst_n          - clock, asynchronous active-low reset
//   Call_EX             - CALL in EX: push Return_Addr_EX
//   Ret_EX              - RET in EX: pop the top entry
//   Return_Addr_EX      - address to push (normally PC+1)
//   Stall_EX            - suppresses every state update this cycle
//   Flush               - synchronous clear of stack and sticky flags
//   Stack_Out_EX        - top-of-stack address (zero when not enabled)
//   Stack_Out_Enable_EX - a valid return target is being supplied
//   Stack_Full/Empty    - count == DEPTH / count == 0
//   Stack_Overflow      - sticky: a push was lost or overwrote an entry
//   Stack_Underflow     - sticky: RET seen while empty
// Build option: define RAS_CIRCULAR_EN to make a push when full overwrite the
// oldest entry; otherwise such a push is dropped.
module return_address_stack
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH  = RAS_DEPTH,
  parameter int unsigned ADDR_W = RAS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Call_EX,
  input  logic              Ret_EX,
  input  logic [ADDR_W-1:0] Return_Addr_EX,
  input  logic              Stall_EX,
  input  logic              Flush,
  output logic [ADDR_W-1:0] Stack_Out_EX,
  output logic              Stack_Out_Enable_EX,
  output logic              Stack_Full,
  output logic              Stack_Empty,
  output logic              Stack_Overflow,
  output logic              Stack_Underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  top_q, top_d, top_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;

  logic              empty, full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Pointer width equals log2(DEPTH), so natural wrap gives mod-DEPTH.
  assign top_inc = top_q + PTR_W'(1);

  ras_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (Return_Addr_EX),
    .raddr (top_q),
    .rdata (rdata)
  );

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    waddr   = top_q;

    if (Flush) begin
      top_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (!Stall_EX) begin
      if (Call_EX && Ret_EX && !empty) begin
        // Tail call: replace the top in place; the old top is output now.
        we = 1'b1;
      end else if (Call_EX) begin
        // Push; Call+Ret on an empty stack lands here as well.
        if (Ret_EX) begin
          udf_d = 1'b1;
        end
        if (full) begin
          ovf_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
          top_d = top_inc;
          we    = 1'b1;
          waddr = top_inc;
`endif
        end else begin
          top_d   = top_inc;
          count_d = count_q + CNT_W'(1);
          we      = 1'b1;
          waddr   = top_inc;
        end
      end else if (Ret_EX) begin
        if (!empty) begin
          top_d   = top_q - PTR_W'(1);
          count_d = count_q - CNT_W'(1);
        end else begin
          udf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign Stack_Out_Enable_EX = Ret_EX & ~empty;
  assign Stack_Out_EX        = Stack_Out_Enable_EX ? rdata : '0;
  assign Stack_Full          = full;
  assign Stack_Empty         = empty;
  assign Stack_Overflow      = ovf_q;
  assign Stack_Underflow     = udf_q;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 16;

  logic              clk;
  logic              rst_n;
  logic              Call_EX, Ret_EX, Stall_EX, Flush;
  logic [ADDR_W-1:0] Return_Addr_EX;
  logic [ADDR_W-1:0] Stack_Out_EX;
  logic              Stack_Out_Enable_EX, Stack_Full, Stack_Empty;
  logic              Stack_Overflow, Stack_Underflow;

  return_address_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .Call_EX             (Call_EX),
    .Ret_EX              (Ret_EX),
    .Return_Addr_EX      (Return_Addr_EX),
    .Stall_EX            (Stall_EX),
    .Flush               (Flush),
    .Stack_Out_EX        (Stack_Out_EX),
    .Stack_Out_Enable_EX (Stack_Out_Enable_EX),
    .Stack_Full          (Stack_Full),
    .Stack_Empty         (Stack_Empty),
    .Stack_Overflow      (Stack_Overflow),
    .Stack_Underflow     (Stack_Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic [ADDR_W-1:0] data;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              udf;
  } exp_t;

  exp_t              expq[$];
  logic [ADDR_W-1:0] stk[$];   // reference stack, back = top
  logic              m_ovf, m_udf;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle the bench drove and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("enable", 32'(Stack_Out_Enable_EX), 32'(e.en));
        chk("data",   32'(Stack_Out_EX),        32'(e.data));
        chk("full",   32'(Stack_Full),          32'(e.full));
        chk("empty",  32'(Stack_Empty),         32'(e.empty));
        chk("ovf",    32'(Stack_Overflow),      32'(e.ovf));
        chk("udf",    32'(Stack_Underflow),     32'(e.udf));
      end
    end
  end

  // Drive one cycle, queue the expected outputs, then advance the model.
  task automatic step(input logic c, input logic r, input logic [ADDR_W-1:0] a,
                      input logic s, input logic f);
    exp_t e;
    @(posedge clk);
    #1;
    Call_EX = c; Ret_EX = r; Return_Addr_EX = a; Stall_EX = s; Flush = f;
    e.en    = r && (stk.size() > 0);
    e.data  = e.en ? stk[$] : '0;
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    expq.push_back(e);
    if (f) begin
      stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (!s) begin
      if (c && r && stk.size() > 0) begin
        stk[$] = a;
      end else if (c) begin
        if (r) m_udf = 1'b1;
        if (stk.size() == DEPTH) begin
          m_ovf = 1'b1;
`ifdef RAS_CIRCULAR_EN
          void'(stk.pop_front());
          stk.push_back(a);
`endif
        end else begin
          stk.push_back(a);
        end
      end else if (r) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_udf = 1'b1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; Call_EX = 1'b0; Ret_EX = 1'b1; Return_Addr_EX = '0;
    Stall_EX = 1'b0; Flush = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    #3;
    chk("rst_enable", 32'(Stack_Out_Enable_EX), 32'd0);
    chk("rst_data",   32'(Stack_Out_EX),        32'd0);
    chk("rst_empty",  32'(Stack_Empty),         32'd1);
    chk("rst_full",   32'(Stack_Full),          32'd0);
    chk("rst_ovf",    32'(Stack_Overflow),      32'd0);
    chk("rst_udf",    32'(Stack_Underflow),     32'd0);
    #4;
    Ret_EX = 1'b0;
    rst_n  = 1'b1;

    // Underflow on an empty stack
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle();

    // LIFO order
    step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0030, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Tail-call replace
    step(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0200, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle();

    // Overflow: push 9 into 8 entries, then drain
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, ADDR_W'(i), 1'b0, 1'b0);
    idle();
    // Tail-call replace while full is not an overflow
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, ADDR_W'(16'h0A00 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0BBB, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, ADDR_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle();

    // Stall suppresses updates; flush overrides stall
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0555, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADDR_W'(16'h0700 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1, 1'b1);
    idle();

    // Asynchronous reset in the middle of a push
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADDR_W'(16'h0900 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);  // leave one cycle of underflow-free state
    @(posedge clk);
    #1;
    Call_EX = 1'b1; Ret_EX = 1'b1; Return_Addr_EX = 16'hABCD;
    #1;
    chk("pre_rst_enable", 32'(Stack_Out_Enable_EX), 32'd1);
    chk("pre_rst_data",   32'(Stack_Out_EX),        32'(stk[$]));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_enable", 32'(Stack_Out_Enable_EX), 32'd0);
    chk("async_rst_data",   32'(Stack_Out_EX),        32'd0);
    chk("async_rst_empty",  32'(Stack_Empty),         32'd1);
    chk("async_rst_full",   32'(Stack_Full),          32'd0);
    stk.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_empty", 32'(Stack_Empty), 32'd1);
    Call_EX = 1'b0; Ret_EX = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 10) < 4, ($urandom % 10) < 4, ADDR_W'($urandom),
           ($urandom % 10) == 0, ($urandom % 50) == 0);
    end
    idle();
    idle();
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
    if (expq.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
